// File: rtl/ysyx_23060096_rf_pkg.sv
// Shared definitions for the register file / scoreboard slice.
//   RF_ADDR_WIDTH : default register index width (32 GPRs)
//   RF_DATA_WIDTH : default register width
//   ZERO_IDX      : index of the hardwired-zero register
// Also provides RF_SLICE, which selects port k from a packed multi-port bus.
`ifndef YSYX_23060096_RF_PKG_SV
`define YSYX_23060096_RF_PKG_SV

// Port k of a bus made of equal-width fields: bus[k*w +: w].
`define RF_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package ysyx_23060096_rf_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned ZERO_IDX      = 0;

endpackage

`endif

// File: rtl/ysyx_23060096_rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   wr_eff, wr_addr  effective writeback (already filtered for x0); clears busy
//   iss_en, iss_addr decode reservation request
//   flush            clears every busy bit
//   busy             current busy vector (one bit per register)
//   iss_ready        reservation can be accepted this cycle
//   busy_cnt         registered popcount of the busy vector
module ysyx_23060096_rf_scoreboard
  import ysyx_23060096_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_eff,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic                    iss_en,
  input  logic [ADDR_WIDTH-1:0]   iss_addr,
  input  logic                    flush,
  output logic [(1<<ADDR_WIDTH)-1:0] busy,
  output logic                    iss_ready,
  output logic [ADDR_WIDTH:0]     busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                iss_zero;
  logic                iss_set;

  assign iss_zero  = ZERO_REG && (iss_addr == ADDR_WIDTH'(ZERO_IDX));
  // A writer retiring this cycle frees its register for a new reservation.
  assign iss_ready = !flush && (!busy_q[iss_addr] || (wr_eff && (wr_addr == iss_addr)));
  assign iss_set   = iss_en && iss_ready && !iss_zero;

  // Later assignments override earlier ones: flush > issue-set > write-clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_eff) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_set) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // Count the next-state vector so busy_cnt tracks busy with no extra lag.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/ysyx_23060096_regfile_sb.sv
// Multi-read-port register file with integrated RAW/WAW scoreboard.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   rd_addr / rd_data  packed read ports, port k at [k*W +: W]
//   rd_busy            per-port: register has a pending writer not satisfied now
//   wr_en/addr/data    writeback
//   iss_en/addr        decode reservation; iss_ready tells whether it is taken
//   flush              clears all busy bits
//   busy_cnt           number of busy registers
module ysyx_23060096_regfile_sb
  import ysyx_23060096_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         iss_ready,
  input  logic                         flush,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  wr_eff;

  assign wr_eff = wr_en && !(ZERO_REG && (wr_addr == ADDR_WIDTH'(ZERO_IDX)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_eff) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  ysyx_23060096_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rstn      (rstn),
    .wr_eff    (wr_eff),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy      (busy),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  pend;

    assign addr = `RF_SLICE(rd_addr, k, ADDR_WIDTH);

    always_comb begin
      data = mem_q[addr];
      pend = busy[addr];
      if (ZERO_REG && (addr == ADDR_WIDTH'(ZERO_IDX))) begin
        data = '0;
        pend = 1'b0;
      end else if (BYPASS && wr_eff && (wr_addr == addr)) begin
        // The retiring write satisfies the reader this cycle.
        data = wr_data;
        pend = 1'b0;
      end
    end

    assign `RF_SLICE(rd_data, k, DATA_WIDTH) = data;
    assign rd_busy[k] = pend;
  end

endmodule
